// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for mem_bus_master: request modes, FSM states and
// AXI response codes. The optional MEM_BUS_RESP_ERR_EN feature uses the
// is_resp_err() helper.
package mem_bus_master_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } mem_bus_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Anything other than OKAY is treated as an error response.
    function automatic logic is_resp_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mem_bus_master_req_slot.sv
// mem_req_slot: one-entry holding buffer for a memory request that arrives
// while the bus master is busy. Push and pop in the same cycle replace the
// held entry with the incoming one. A push into a full slot is dropped.
module mem_req_slot
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic                i_mode,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    output logic                o_valid,
    output logic                o_mode,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb
);

    logic                r_valid;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                w_load;

    assign w_load = i_push && (!r_valid || i_pop);

    // Occupancy flag: set by any push, cleared by a pop without a push.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: flops use <= so every register samples pre-edge values.
        if (!rstn) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_push || (r_valid && !i_pop);
        end
    end

    // Payload capture.
    always_ff @(posedge clk) begin
        // NOTE: payload is only read while r_valid is set, so it needs no reset.
        if (w_load) begin
            r_mode  <= i_mode;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wstrb <= i_wstrb;
        end
    end

`ifndef SYNTHESIS
    // Flag a request lost because the slot was already occupied.
    always_ff @(posedge clk) begin
        if (rstn && i_push && r_valid && !i_pop) begin
            $error("mem_req_slot: slot full, request dropped");
        end
    end
`endif

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_wstrb = r_wstrb;

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: turns single-cycle memory requests into AXI4-Lite master
// transactions and answers with a one-cycle resp_enable pulse. One request
// can wait in a pending slot while a transaction is in flight.
// Optional feature macro: MEM_BUS_RESP_ERR_EN adds sticky err/err_addr.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [2:0] AXPROT = 3'b000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_enable,
    input  logic                req_mode,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_enable,
    output logic [DATA_W-1:0]   resp_data,
    output logic                busy,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
`ifdef MEM_BUS_RESP_ERR_EN
    ,
    output logic                err,
    output logic [ADDR_W-1:0]   err_addr
`endif
);

    localparam int STRB_W = DATA_W / 8;

    // Every bus-facing output is a flop, so valid/payload never glitch.
    typedef struct packed {
        logic              arvalid;
        logic [ADDR_W-1:0] araddr;
        logic              rready;
        logic              awvalid;
        logic [ADDR_W-1:0] awaddr;
        logic              wvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              bready;
        logic              resp_enable;
        logic [DATA_W-1:0] resp_data;
    } bus_regs_t;

    mem_bus_state_t    r_state, w_state_next;
    bus_regs_t         r_bus, w_bus_next;

    logic              w_slot_valid, w_slot_mode, w_slot_push, w_slot_pop;
    logic [ADDR_W-1:0] w_slot_addr;
    logic [DATA_W-1:0] w_slot_wdata;
    logic [STRB_W-1:0] w_slot_wstrb;

    logic              w_src_valid, w_src_mode;
    logic [ADDR_W-1:0] w_src_addr;
    logic [DATA_W-1:0] w_src_wdata;
    logic [STRB_W-1:0] w_src_wstrb;

    logic              w_rd_done, w_wr_done;

    // A waiting request always goes first; a new one arriving then, or while
    // a transaction is in flight, takes its place in the slot.
    assign w_slot_pop  = (r_state == ST_IDLE) && w_slot_valid;
    assign w_slot_push = req_enable && ((r_state != ST_IDLE) || w_slot_valid);

    assign w_src_valid = w_slot_valid || req_enable;
    assign w_src_mode  = w_slot_valid ? w_slot_mode  : req_mode;
    assign w_src_addr  = w_slot_valid ? w_slot_addr  : req_addr;
    assign w_src_wdata = w_slot_valid ? w_slot_wdata : req_wdata;
    assign w_src_wstrb = w_slot_valid ? w_slot_wstrb : req_wstrb;

    assign w_rd_done = (r_state == ST_RD_DATA) && m_axi_rvalid && r_bus.rready;
    assign w_wr_done = (r_state == ST_WR_RESP) && m_axi_bvalid && r_bus.bready;

    mem_req_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_slot_push),
        .i_pop   (w_slot_pop),
        .i_mode  (req_mode),
        .i_addr  (req_addr),
        .i_wdata (req_wdata),
        .i_wstrb (req_wstrb),
        .o_valid (w_slot_valid),
        .o_mode  (w_slot_mode),
        .o_addr  (w_slot_addr),
        .o_wdata (w_slot_wdata),
        .o_wstrb (w_slot_wstrb)
    );

    // Next-state and next bus-register values.
    always_comb begin
        // NOTE: defaults come first so no path leaves a target unassigned (no latches).
        w_state_next           = r_state;
        w_bus_next             = r_bus;
        w_bus_next.resp_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_src_valid) begin
                    if (w_src_mode == MEMREQ_READ) begin
                        w_bus_next.araddr  = w_src_addr;
                        w_bus_next.arvalid = 1'b1;
                        w_state_next       = ST_RD_ADDR;
                    end else begin
                        w_bus_next.awaddr  = w_src_addr;
                        w_bus_next.wdata   = w_src_wdata;
                        w_bus_next.wstrb   = w_src_wstrb;
                        w_bus_next.awvalid = 1'b1;
                        w_bus_next.wvalid  = 1'b1;
                        w_state_next       = ST_WR_REQ;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    w_bus_next.arvalid = 1'b0;
                    w_bus_next.rready  = 1'b1;
                    w_state_next       = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (w_rd_done) begin
                    w_bus_next.resp_data   = m_axi_rdata;
                    w_bus_next.resp_enable = 1'b1;
                    w_bus_next.rready      = 1'b0;
                    w_state_next           = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently, in any order.
                if (m_axi_awready) w_bus_next.awvalid = 1'b0;
                if (m_axi_wready)  w_bus_next.wvalid  = 1'b0;
                if ((!r_bus.awvalid || m_axi_awready) && (!r_bus.wvalid || m_axi_wready)) begin
                    w_bus_next.bready = 1'b1;
                    w_state_next      = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (w_wr_done) begin
                    w_bus_next.resp_data   = '0;
                    w_bus_next.resp_enable = 1'b1;
                    w_bus_next.bready      = 1'b0;
                    w_state_next           = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and registered bus outputs; reset abandons any transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_bus   <= '0;
        end else begin
            r_state <= w_state_next;
            r_bus   <= w_bus_next;
        end
    end

`ifdef MEM_BUS_RESP_ERR_EN
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    // Sticky capture of the first failing response and its address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (!r_err) begin
            if (w_rd_done && is_resp_err(m_axi_rresp)) begin
                r_err      <= 1'b1;
                r_err_addr <= r_bus.araddr;
            end else if (w_wr_done && is_resp_err(m_axi_bresp)) begin
                r_err      <= 1'b1;
                r_err_addr <= r_bus.awaddr;
            end
        end
    end

    assign err      = r_err;
    assign err_addr = r_err_addr;
`else
    // Response codes are ignored in this build.
    logic w_unused_resp;
    assign w_unused_resp = ^{m_axi_rresp, m_axi_bresp};
`endif

    assign resp_enable   = r_bus.resp_enable;
    assign resp_data     = r_bus.resp_data;
    assign busy          = (r_state != ST_IDLE) || w_slot_valid;
    assign m_axi_awaddr  = r_bus.awaddr;
    assign m_axi_awprot  = AXPROT;
    assign m_axi_awvalid = r_bus.awvalid;
    assign m_axi_wdata   = r_bus.wdata;
    assign m_axi_wstrb   = r_bus.wstrb;
    assign m_axi_wvalid  = r_bus.wvalid;
    assign m_axi_bready  = r_bus.bready;
    assign m_axi_araddr  = r_bus.araddr;
    assign m_axi_arprot  = AXPROT;
    assign m_axi_arvalid = r_bus.arvalid;
    assign m_axi_rready  = r_bus.rready;

endmodule
